// File: rtl/cpu_seq_pkg.sv
// Shared encodings for the multi-cycle execution sequencer, the ALU and the control decoder.
// Holds the state enum, opcode constants and ALU operation codes.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HOST      = 3'd5
  } seq_state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_JMP = 2'b11;

  localparam logic [2:0] ALU_NOP = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  function automatic logic [2:0] alu_decode(input logic [1:0] op);
    case (op)
      OP_ADD:  alu_decode = ALU_ADD;
      OP_AND:  alu_decode = ALU_AND;
      OP_OR:   alu_decode = ALU_OR;
      default: alu_decode = ALU_NOP;
    endcase
  endfunction

endpackage

// File: rtl/cpu_exec_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer with run/step control and
// instruction-boundary arbitration of the register-file port between core and host.
module cpu_exec_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int HOST_MAX = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic [1:0]       opcode,
  input  logic             dbg_req,
  input  logic             dbg_we,
  output logic             ir_load,
  output logic             pc_load,
  output logic             pc_jump,
  output logic             rf_we,
  output logic             rf_sel_host,
  output logic             dbg_gnt,
  output logic [2:0]       alu_op,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [7:0] HOST_LAST = 8'(HOST_MAX - 1);

  seq_state_e       state_q, state_d;
  logic             step_q, step_d;
  logic [1:0]       op_q, op_d;
  logic             fair_q, fair_d;
  logic [7:0]       host_cnt_q, host_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      step_q     <= 1'b0;
      op_q       <= OP_ADD;
      fair_q     <= 1'b0;
      host_cnt_q <= 8'd0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      op_q       <= op_d;
      fair_q     <= fair_d;
      host_cnt_q <= host_cnt_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    op_d        = op_q;
    fair_d      = fair_q;
    host_cnt_d  = host_cnt_q;
    cnt_d       = cnt_q;
    ir_load     = 1'b0;
    pc_load     = 1'b0;
    pc_jump     = 1'b0;
    rf_we       = 1'b0;
    rf_sel_host = 1'b0;
    dbg_gnt     = 1'b0;
    alu_op      = ALU_NOP;

    case (state_q)
      S_IDLE: begin
        // fair_q keeps a timed-out host from starving the core of at least one instruction
        if (dbg_req && !fair_q) begin
          state_d    = S_HOST;
          host_cnt_d = 8'd0;
        end else if (run) begin
          state_d = S_FETCH;
          step_d  = 1'b0;
        end else if (step) begin
          state_d = S_FETCH;
          step_d  = 1'b1;
        end
      end
      S_FETCH: begin
        ir_load = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        op_d    = opcode;
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        alu_op  = alu_decode(op_q);
        state_d = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        alu_op  = alu_decode(op_q);
        pc_load = 1'b1;
        pc_jump = (op_q == OP_JMP);
        rf_we   = (op_q != OP_JMP);
        cnt_d   = cnt_q + CNT_W'(1);
        fair_d  = 1'b0;
        step_d  = 1'b0;
        if (dbg_req) begin
          state_d    = S_HOST;
          host_cnt_d = 8'd0;
        end else if (step_q || !run) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_HOST: begin
        rf_sel_host = 1'b1;
        dbg_gnt     = 1'b1;
        rf_we       = dbg_we & dbg_req;
        // Timer saturates so a host that outlives run=0 is revoked as soon as run rises
        if (!dbg_req) begin
          state_d    = S_IDLE;
          host_cnt_d = 8'd0;
        end else if (run && host_cnt_q == HOST_LAST) begin
          state_d    = S_IDLE;
          fair_d     = 1'b1;
          host_cnt_d = 8'd0;
        end else if (host_cnt_q != HOST_LAST) begin
          host_cnt_d = host_cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign halted      = (state_q == S_IDLE);
  assign state       = state_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_cpu_exec_sequencer.sv
// Randomized and directed stimulus for cpu_exec_sequencer, checked every cycle against
// an instruction-level behavioural model; a second instance with a 4-bit counter checks wrap.
module tb_cpu_exec_sequencer;

  localparam int HOST_MAX = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0, step = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
  logic [1:0]  opcode = 2'b00;

  logic        ir_load, pc_load, pc_jump, rf_we, rf_sel_host, dbg_gnt, halted;
  logic [2:0]  alu_op, state;
  logic [15:0] instr_count;

  logic        w4_ir_load, w4_pc_load, w4_pc_jump, w4_rf_we, w4_rf_sel_host, w4_dbg_gnt, w4_halted;
  logic [2:0]  w4_alu_op, w4_state;
  logic [3:0]  w4_instr_count;

  cpu_exec_sequencer #(.CNT_W(16), .HOST_MAX(HOST_MAX)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .opcode(opcode),
    .dbg_req(dbg_req), .dbg_we(dbg_we),
    .ir_load(ir_load), .pc_load(pc_load), .pc_jump(pc_jump), .rf_we(rf_we),
    .rf_sel_host(rf_sel_host), .dbg_gnt(dbg_gnt), .alu_op(alu_op),
    .halted(halted), .state(state), .instr_count(instr_count)
  );

  cpu_exec_sequencer #(.CNT_W(4), .HOST_MAX(HOST_MAX)) dut4 (
    .clk(clk), .rst(rst), .run(run), .step(step), .opcode(opcode),
    .dbg_req(dbg_req), .dbg_we(dbg_we),
    .ir_load(w4_ir_load), .pc_load(w4_pc_load), .pc_jump(w4_pc_jump), .rf_we(w4_rf_we),
    .rf_sel_host(w4_rf_sel_host), .dbg_gnt(w4_dbg_gnt), .alu_op(w4_alu_op),
    .halted(w4_halted), .state(w4_state), .instr_count(w4_instr_count)
  );

  always #5 clk = ~clk;

  // Model: either inside an instruction (stage 0..3), holding the host grant, or idle.
  bit          m_instr, m_host, m_fair, m_single;
  int          m_stage, m_hcyc;
  logic [1:0]  m_op;
  int unsigned m_retired;
  int          n_checks = 0, n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [2:0] exp_alu(input logic [1:0] op);
    case (op)
      2'b00:   return 3'b001;
      2'b01:   return 3'b010;
      2'b10:   return 3'b011;
      default: return 3'b000;
    endcase
  endfunction

  task automatic model_reset();
    m_instr = 0; m_host = 0; m_fair = 0; m_single = 0;
    m_stage = 0; m_hcyc = 0; m_op = 2'b00; m_retired = 0;
  endtask

  task automatic model_step();
    if (m_host) begin
      m_hcyc++;
      if (!dbg_req) m_host = 0;
      else if (run && m_hcyc >= HOST_MAX) begin
        m_host = 0;
        m_fair = 1;
      end
    end else if (m_instr) begin
      if (m_stage == 1) m_op = opcode;
      if (m_stage == 3) begin
        m_retired++;
        m_fair = 0;
        m_instr = 0;
        if (dbg_req) begin
          m_host = 1; m_hcyc = 0;
        end else if (!(m_single || !run)) begin
          m_instr = 1; m_stage = 0;
        end
        m_single = 0;
      end else begin
        m_stage++;
      end
    end else begin
      if (dbg_req && !m_fair) begin
        m_host = 1; m_hcyc = 0;
      end else if (run) begin
        m_instr = 1; m_stage = 0; m_single = 0;
      end else if (step) begin
        m_instr = 1; m_stage = 0; m_single = 1;
      end
    end
  endtask

  task automatic check_outputs();
    logic       e_ir, e_pcl, e_jmp, e_we, e_host, e_halt;
    logic [2:0] e_alu, e_state;
    e_ir    = m_instr && m_stage == 0;
    e_pcl   = m_instr && m_stage == 3;
    e_jmp   = e_pcl && m_op == 2'b11;
    e_we    = (e_pcl && m_op != 2'b11) || (m_host && dbg_we && dbg_req);
    e_host  = m_host;
    e_halt  = !m_instr && !m_host;
    e_alu   = (m_instr && m_stage >= 2) ? exp_alu(m_op) : 3'b000;
    e_state = m_instr ? 3'(m_stage + 1) : (m_host ? 3'd5 : 3'd0);
    chk("ir_load", 32'(ir_load), 32'(e_ir));
    chk("pc_load", 32'(pc_load), 32'(e_pcl));
    chk("pc_jump", 32'(pc_jump), 32'(e_jmp));
    chk("rf_we", 32'(rf_we), 32'(e_we));
    chk("rf_sel_host", 32'(rf_sel_host), 32'(e_host));
    chk("dbg_gnt", 32'(dbg_gnt), 32'(e_host));
    chk("alu_op", 32'(alu_op), 32'(e_alu));
    chk("halted", 32'(halted), 32'(e_halt));
    chk("state", 32'(state), 32'(e_state));
    chk("instr_count", 32'(instr_count), 32'(m_retired[15:0]));
    chk("count4", 32'(w4_instr_count), 32'(m_retired[3:0]));
    chk("dut4_ctl",
        32'({w4_ir_load, w4_pc_load, w4_pc_jump, w4_rf_we, w4_rf_sel_host, w4_dbg_gnt,
             w4_alu_op, w4_halted, w4_state}),
        32'({e_ir, e_pcl, e_jmp, e_we, e_host, e_host, e_alu, e_halt, e_state}));
  endtask

  task automatic cyc(input logic rs, input logic r, input logic s, input logic [1:0] op,
                     input logic dq, input logic dw);
    @(negedge clk);
    rst = rs; run = r; step = s; opcode = op; dbg_req = dq; dbg_we = dw;
    if (rst) model_reset();
    #1 check_outputs();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
  endtask

  initial begin
    logic       r, s, dq, dw, rs;
    logic [1:0] op;
    model_reset();

    // Reset state
    repeat (2) cyc(1, 0, 0, 2'b00, 0, 0);

    // Continuous run, OR opcode
    for (int i = 0; i < 12; i++) cyc(0, 1, 0, 2'b10, 0, 0);
    repeat (6) cyc(0, 0, 0, 2'b10, 0, 0);

    // Single step of a jump; a second pulse during EXECUTE is ignored
    for (int i = 0; i < 9; i++) cyc(0, 0, (i == 0 || i == 3), 2'b11, 0, 0);

    // Host request during EXECUTE under run: grant at boundary, timeout, fairness
    for (int i = 0; i < 40; i++) cyc(0, 1, 0, 2'(i), (i >= 3 && i < 30), 1);
    repeat (6) cyc(0, 0, 0, 2'b00, 0, 0);

    // Halted host access: no timeout while run=0
    repeat (22) cyc(0, 0, 0, 2'b01, 1, 1);
    repeat (3) cyc(0, 0, 0, 2'b01, 0, 0);

    // Long run for counter wrap on the 4-bit instance
    for (int i = 0; i < 80; i++) cyc(0, 1, 0, 2'(i % 3), 0, 0);
    repeat (6) cyc(0, 0, 0, 2'b00, 0, 0);

    // Reset asserted during DECODE
    repeat (2) cyc(0, 1, 0, 2'b00, 0, 0);
    repeat (2) cyc(1, 1, 0, 2'b00, 0, 0);
    repeat (4) cyc(0, 0, 0, 2'b00, 0, 0);

    // Randomized traffic
    r = 0; dq = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) r = ~r;
      if ($urandom_range(0, 14) == 0) dq = ~dq;
      s  = ($urandom_range(0, 19) == 0);
      dw = 1'($urandom);
      op = 2'($urandom);
      rs = ($urandom_range(0, 499) == 0);
      cyc(rs, r, s, op, dq, dw);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu_exec_sequencer.md
Name: cpu_exec_sequencer

Overview:
Multi-cycle control sequencer for the 8-bit accumulator-less datapath (PC, instruction memory, 4x8 register file, ALU).
- Replaces the single-cycle control path: steps each instruction through FETCH/DECODE/EXECUTE/WRITEBACK.
- Provides run/halt/single-step control.
- Arbitrates the register-file write/read port between the core and a host debug port, granting the host only at instruction boundaries.

Parameters:
CNT_W, 16, width of retired-instruction counter
HOST_MAX, 8, max consecutive HOST cycles while run=1 before grant is revoked (1..255)

Ports:
clk  input  1  clock
rst  input  1  reset
run  input  1  level; 1 = execute continuously
step  input  1  one-cycle pulse; execute exactly one instruction when halted
opcode  input  2  instruction[7:6] from instruction register
dbg_req  input  1  host requests register-file access (level, held until done)
dbg_we  input  1  host write enable, valid while dbg_gnt=1
ir_load  output  1  load instruction register from instruction memory
pc_load  output  1  update PC
pc_jump  output  1  with pc_load: PC <= 0, else PC <= PC+1
rf_we  output  1  register-file write strobe
rf_sel_host  output  1  register-file address/data mux select, 1 = host
dbg_gnt  output  1  host owns register file this cycle
alu_op  output  3  ALU operation code
halted  output  1  sequencer in IDLE
state  output  3  current state encoding (debug)
instr_count  output  CNT_W  retired-instruction counter

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
- Reset values:
  - state=IDLE, halted=1.
  - ir_load, pc_load, pc_jump, rf_we, rf_sel_host, dbg_gnt all 0.
  - alu_op=000, instr_count=0.
  - Internal step_q=0, op_q=00, fair_q=0, host_cnt=0.
- Reset mid-instruction abandons it: no rf_we, no pc_load, no count increment.
- States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, HOST=5. Codes 6/7 go to IDLE.
- All outputs are decoded from registered state/op_q (Moore), except rf_we in HOST = dbg_we & dbg_req (combinational).
- IDLE (halted=1):
  - Priority 1: dbg_req & !fair_q -> HOST.
  - Priority 2: run -> FETCH.
  - Priority 3: step -> FETCH with step_q=1.
  - run and step together: run wins, step_q=0.
  - step while not in IDLE is ignored.
- FETCH: ir_load=1 for exactly one cycle -> DECODE.
- DECODE: op_q <= opcode -> EXECUTE.
- EXECUTE: ALU settles, no strobes -> WRITEBACK.
- alu_op mapping, driven from DECODE+1 (EXECUTE, WRITEBACK) from op_q: 00->001 ADD, 01->010 AND, 10->011 OR, 11->000. alu_op=000 in all other states.
- WRITEBACK:
  - op_q != 11: rf_we=1, pc_load=1, pc_jump=0.
  - op_q == 11: rf_we=0, pc_load=1, pc_jump=1.
  - instr_count += 1, wrapping from all-ones to 0. fair_q <= 0.
  - Next state:
    - dbg_req -> HOST.
    - else step_q | !run -> IDLE, step_q cleared.
    - else FETCH.
- Latency: 4 cycles per instruction; back-to-back under run=1, with no bubble between WRITEBACK and the next FETCH.
- HOST: rf_sel_host=1, dbg_gnt=1, host_cnt increments each cycle.
  - dbg_req low -> IDLE, host_cnt=0.
  - run=1 and host_cnt==HOST_MAX-1 -> grant revoked: IDLE, fair_q=1, host_cnt=0.
  - fair_q blocks re-grant until one WRITEBACK completes.
  - With run=0 there is no timeout; the host holds the port indefinitely.
- run deasserted mid-instruction: current instruction completes, then IDLE.
- Core never writes the register file while dbg_gnt=1; host never writes outside HOST.

Decomposition:
- Shared package cpu_seq_pkg holds:
  - State enum.
  - Opcode constants OP_ADD=00, OP_AND=01, OP_OR=10, OP_JMP=11.
  - ALU codes ALU_NOP=000, ALU_ADD=001, ALU_AND=010, ALU_OR=011.
  - Reused by the ALU and the existing control decoder.
- Single module; no sub-module is warranted. The counter and host timer are inline.

Test Plan:
- Reset then run=1, opcode=10 constant:
  - ir_load high on cycles 1, 5, 9.
  - alu_op=011 in cycles 3-4.
  - rf_we and pc_load high on cycle 4.
  - instr_count=2 after cycle 8.
- Halted, step pulse, opcode=11:
  - Exactly one FETCH..WRITEBACK.
  - pc_load=1 with pc_jump=1 and rf_we=0 in WRITEBACK.
  - Returns to IDLE with halted=1 and instr_count=1.
  - A second step pulse during EXECUTE is ignored.
- run=1, dbg_req asserted during EXECUTE:
  - Grant not given until after WRITEBACK, then HOST for HOST_MAX=8 cycles with dbg_gnt=1.
  - Then revoked; FETCH follows IDLE.
  - Next grant only after the following WRITEBACK.
- run=0, dbg_req=1 with dbg_we=1 for 20 cycles:
  - dbg_gnt and rf_sel_host stay 1 for all 20 cycles; rf_we=1 throughout; no timeout.
  - Drop dbg_req -> IDLE next cycle.
- instr_count with CNT_W=4 preset via 15 instructions: the 16th retire wraps the count to 0.
- Assert rst during DECODE:
  - All outputs 0 and halted=1 immediately.
  - No rf_we/pc_load pulse and instr_count=0 after release.
